// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and widths for the 16-bit SRAM memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

endpackage : sram_ctrl_pkg

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module      : sram_wait_counter
// Description : Loadable down-counter timing one SRAM half-access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so an idle controller keeps the counter parked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule : sram_wait_counter

`default_nettype wire

// File: rtl/sram_mem_controller.sv
// ============================================================================
// Module      : sram_mem_controller
// Description : Splits 32-bit MEM-stage accesses into two 16-bit async SRAM
//               half-accesses; optional alignment check via
//               SRAM_CTRL_ALIGN_CHECK_EN (adds the err port).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam logic [WAIT_CNT_W-1:0] c_LOAD_VAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_t                r_state;
    sram_state_t                w_next;
    logic                       w_req;
    logic                       w_load;
    logic                       w_zero;
    logic                       w_misalign;
    logic                       w_active;
    logic                       w_half;
    logic [31:0]                w_offset;
    logic                       r_is_wr;
    logic [SRAM_ADDR_W-2:0]     r_word;
    logic [31:0]                r_wdata;
    logic [SRAM_DATA_W-1:0]     r_stage;
    logic [31:0]                r_read_data;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - ADDR_BASE;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign = |w_offset[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    sram_wait_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (c_LOAD_VAL),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_misalign) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_LOW;
                        w_load = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (w_zero) begin
                    w_next = ST_HIGH;
                    w_load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_zero) begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch; write wins when both enables are raised together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_stage     <= '0;
            r_read_data <= '0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_is_wr <= wr_en;
                r_word  <= w_offset[18:2];
                r_wdata <= write_data;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
                r_misalign <= w_misalign;
`endif
            end
            if (r_state == ST_LOW && w_zero && !r_is_wr) begin
                r_stage <= sram_dq_in;
            end
            if (r_state == ST_HIGH && w_zero && !r_is_wr) begin
                r_read_data <= {sram_dq_in, r_stage};
            end
        end
    end

    assign w_active = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_half   = (r_state == ST_HIGH);

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        if (w_active) begin
            sram_addr = {r_word, w_half};
            if (r_is_wr) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = w_half ? r_wdata[31:16] : r_wdata[15:0];
            end
        end
    end

    assign ready     = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);
    assign read_data = r_read_data;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
    assign err = (r_state == ST_DONE) && r_misalign;
`endif

endmodule : sram_mem_controller

`default_nettype wire
